// File: rtl/fcpu_pkg.sv
// Shared types and constants for the fcpu
// out-of-order core.
package fcpu_pkg;

  localparam int RSV_ID_W = 5;
  localparam int DATA_W   = 32;

  typedef struct packed {
    logic [RSV_ID_W-1:0] rsv_id;
    logic [DATA_W-1:0]   data;
  } cdb_t;

  localparam int CDB_W     = $bits(cdb_t);
  localparam int N_CDB_REQ = 4;

  typedef enum logic [1:0] {
    cdb_req_alu = 2'd0,
    cdb_req_fpu = 2'd1,
    cdb_req_mem = 2'd2,
    cdb_req_br  = 2'd3
  } cdb_req_e;

endpackage

// File: rtl/fcpu_rr_pick.sv
// Combinational round-robin picker: first set
// request at or after ptr, wrapping.
module fcpu_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int j;

  // Scan from farthest to nearest so the
  // nearest requester overwrites the others.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fcpu_cdb_arbiter.sv
// Common data bus arbiter: round-robin grant,
// one-cycle registered broadcast, flush, counter.
module fcpu_cdb_arbiter
  import fcpu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = RSV_ID_W,
  parameter int DW    = DATA_W
) (
  input  logic                  clk,
  input  logic                  xrst,
  input  logic                  flush,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*ID_W-1:0] req_rsv_id,
  input  logic [N_REQ*DW-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  cdb_valid,
  output logic [ID_W-1:0]       cdb_rsv_id,
  output logic [DW-1:0]         cdb_data,
  output logic [31:0]           bcast_cnt
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             vld_q, vld_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [DW-1:0]    data_q, data_d;
  logic [31:0]      cnt_q, cnt_d;

  logic [N_REQ-1:0] req_eff;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gidx;
  logic             xfer;

  // Nothing may be granted while flushing or
  // in reset, so the picker sees no requests.
  assign req_eff = (xrst && !flush) ? req_valid : '0;

  fcpu_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i (req_eff),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (xfer)
  );

  assign req_ready  = gnt;
  assign cdb_valid  = vld_q;
  assign cdb_rsv_id = id_q;
  assign cdb_data   = data_q;
  assign bcast_cnt  = cnt_q;

  always_comb begin
    ptr_d  = ptr_q;
    vld_d  = 1'b0;
    id_d   = id_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (xfer) begin
      vld_d = 1'b1;
      cnt_d = cnt_q + 32'd1;
      if (gidx == IDX_W'(N_REQ - 1)) ptr_d = '0;
      else ptr_d = gidx + IDX_W'(1);
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i]) begin
          id_d   = req_rsv_id[i*ID_W +: ID_W];
          data_d = req_data[i*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!xrst) begin
      ptr_q  <= '0;
      vld_q  <= 1'b0;
      id_q   <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      vld_q  <= vld_d;
      id_q   <= id_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: doc/fcpu_cdb_arbiter.md
Name: fcpu_cdb_arbiter

Overview:
Round-robin scheduler sharing the single common data bus (CDB) among the functional units (integer ALU, FPU, memory, branch). Each cycle it picks at most one completed result, presented as {reservation-station id, data}, and broadcasts it one cycle later to the reservation stations and the reorder buffer. It also honours a pipeline flush on branch mispredict and keeps a broadcast counter for performance monitoring.

Parameters:
N_REQ, 4, number of requesting functional units (2..8)
ID_W, fcpu_pkg::RSV_ID_W (5), reservation-station id width
DW, fcpu_pkg::DATA_W (32), result data width

Ports:
clk  in  1  clock, all state updates on the rising edge
xrst  in  1  synchronous active-low reset
flush  in  1  mispredict flush, active high
req_valid  in  N_REQ  requester i has a result
req_rsv_id  in  N_REQ*ID_W  packed ids, requester i at [i*ID_W +: ID_W]
req_data  in  N_REQ*DW  packed data, requester i at [i*DW +: DW]
req_ready  out  N_REQ  one-hot grant, combinational
cdb_valid  out  1  broadcast valid, registered
cdb_rsv_id  out  ID_W  broadcast tag, registered
cdb_data  out  DW  broadcast data, registered
bcast_cnt  out  32  broadcasts since reset, wraps

Behaviour:
- Reset (xrst=0 at an edge): cdb_valid=0, cdb_rsv_id=0, cdb_data=0, bcast_cnt=0, priority pointer ptr=0. xrst overrides flush and any requests. A handshake in the reset cycle is discarded.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i] at an edge.
  - A requester holds req_valid, id and data stable until granted.
  - req_ready never depends on the requester's own payload.
- Arbitration (combinational, cycle T):
  - Winner g = first i with req_valid[i], scanning ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1.
  - req_ready = one-hot(g). It is all-zero if no request, flush=1 or xrst=0.
- Broadcast (registered, cycle T+1):
  - On a transfer: cdb_valid=1, cdb_rsv_id/cdb_data = requester g payload.
  - Latency is exactly 1 cycle. Throughput is 1 result per cycle.
- Pointer: on a transfer, ptr <= (g+1) mod N_REQ, wrapping from N_REQ-1 to 0. With no transfer, ptr holds.
- Idle: with no transfer, cdb_valid<=0. cdb_rsv_id and cdb_data hold their last values; consumers qualify them with cdb_valid.
- Flush:
  - The flush cycle grants nothing, and cdb_valid<=0 at the next edge.
  - ptr and bcast_cnt hold.
  - A cdb_valid already high during the flush cycle is not retracted; the ROB discards it.
  - Requesters are expected to drop squashed requests themselves.
- Simultaneous requests: exactly one grant. Losers stay pending and win within N_REQ-1 further transfer cycles (starvation-free).
- bcast_cnt: increments by 1 on every transfer and wraps from 0xFFFFFFFF to 0.
- Single requester repeatedly valid: granted every cycle, giving back-to-back cdb_valid.

Decomposition:
- fcpu_pkg gains:
  - typedef struct packed {logic [RSV_ID_W-1:0] rsv_id; logic [DATA_W-1:0] data;} cdb_t, of width CDB_W.
  - localparam N_CDB_REQ = 4.
  - An enum of requester indices: cdb_req_alu=0, cdb_req_fpu=1, cdb_req_mem=2, cdb_req_br=3.
- Sub-module fcpu_rr_pick is natural: combinational, from (N_REQ, req vector, ptr) to (one-hot grant, index g, any). It is reusable for future issue arbiters. The register stage, flush and counter stay in fcpu_cdb_arbiter.

Test Plan:
- Reset then idle: hold xrst=0 for 2 cycles, release, all req_valid=0 for 5 cycles -> cdb_valid=0, req_ready=0000, bcast_cnt=0 throughout.
- Single transfer: cycle T, req_valid=0100, id[2]=5'd7, data[2]=32'hDEADBEEF -> req_ready=0100 at T; at T+1 cdb_valid=1, cdb_rsv_id=7, cdb_data=DEADBEEF, bcast_cnt=1; ptr=3.
- Round-robin fairness: all four requests held valid from ptr=0 -> grants 0,1,2,3,0 on consecutive cycles; five back-to-back cdb_valid=1 cycles, each with the matching tag.
- Wrap and skip: ptr=3, req_valid=0011 -> grant requester 0 first, then 1; ptr ends at 2.
- Flush: req_valid=1111 with flush=1 at cycle T -> req_ready=0000 at T, cdb_valid=0 at T+1, ptr and bcast_cnt unchanged; at T+1 (flush=0) the grant goes to the same requester as before the flush.
- Reset mid-stream: requests active, cdb_valid=1, then xrst=0 for one edge -> next cycle cdb_valid=0, bcast_cnt=0, ptr=0; the first grant after release goes to requester 0.
